// File: rtl/seg7_pkg.sv
// Shared glyphs, FSM state type and nibble lookup for the multi-digit 7-segment driver.
// Glyphs are stored active-low as {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Codes 10..15 never leave a correct double-dabble pass, so they show as blank.
  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    case (nibble)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to 8-bit segment pattern (dp always off), with dash and
// blank overrides; ACTIVE_LOW=0 inverts the whole pattern.
module seg7_encode #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [7:0] seg_o
);
  import seg7_pkg::*;

  logic [6:0] glyphLow;
  logic [7:0] patternLow;

  // Overflow dash takes priority over leading-zero blanking.
  always_comb begin
    if (dash_i) begin
      glyphLow = SEG_DASH;
    end else if (blank_i) begin
      glyphLow = SEG_BLANK;
    end else begin
      glyphLow = glyph(nibble_i);
    end
  end

  assign patternLow = {1'b1, glyphLow};
  assign seg_o      = (ACTIVE_LOW != 0) ? patternLow : ~patternLow;

endmodule

// File: rtl/seg7_multi_digit_driver.sv
// Binary value to DIGITS-digit 7-segment display through a sequential double-dabble engine.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero one.
module seg7_multi_digit_driver #(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = 6,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [DATA_W-1:0]   iVALUE,
  input  logic                iLOAD,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oOVF,
  output logic [8*DIGITS-1:0] oSEG
);
  import seg7_pkg::*;

  localparam int                 CNT_W      = $clog2(DATA_W + 1);
  localparam int                 BCD_W      = 4 * DIGITS;
  localparam int                 SEG_W      = 8 * DIGITS;
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [7:0]         BLANK_BYTE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [SEG_W-1:0]   BLANK_ALL  = {DIGITS{BLANK_BYTE}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovfSticky_q, ovfSticky_d;
  logic                pendValid_q, pendValid_d;
  logic [DATA_W-1:0]   pendValue_q, pendValue_d;
  logic [SEG_W-1:0]    segStage_q, segStage_d;
  logic                ovfStage_q, ovfStage_d;
  logic                publish_q, publish_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                ovfOut_q, ovfOut_d;
  logic                done_q, done_d;

  logic [BCD_W-1:0]    bcdAdj;
  logic [DIGITS-1:0]   blankMask;
  logic [SEG_W-1:0]    encSeg;
  logic                loadEn;
  logic [DATA_W-1:0]   loadValue;

  // Add-3 correction on every nibble that would reach 10 or more after the shift.
  always_comb begin
    bcdAdj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcdAdj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upperZero;

  always_comb begin
    upperZero = 1'b1;
    blankMask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upperZero    = upperZero & (bcd_q[4*k +: 4] == 4'd0);
      blankMask[k] = upperZero & (k != 0);
    end
  end
`else
  assign blankMask = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_encode #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_encode (
      .nibble_i (bcd_q[4*k +: 4]),
      .blank_i  (blankMask[k]),
      .dash_i   (ovfSticky_q),
      .seg_o    (encSeg[8*k +: 8])
    );
  end

  // Encoded result is staged in UPDATE and published one cycle later with the done pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    ovfSticky_d = ovfSticky_q;
    pendValid_d = pendValid_q;
    pendValue_d = pendValue_q;
    segStage_d  = segStage_q;
    ovfStage_d  = ovfStage_q;
    publish_d   = 1'b0;
    done_d      = publish_q;
    seg_d       = seg_q;
    ovfOut_d    = ovfOut_q;
    loadEn      = 1'b0;
    loadValue   = iVALUE;

    if (publish_q) begin
      seg_d    = segStage_q;
      ovfOut_d = ovfStage_q;
    end

    case (state_q)
      IDLE: begin
        if (iLOAD) begin
          loadEn      = 1'b1;
          pendValid_d = 1'b0;
        end else if (pendValid_q) begin
          loadEn      = 1'b1;
          loadValue   = pendValue_q;
          pendValid_d = 1'b0;
        end
      end
      SHIFT: begin
        bcd_d       = {bcdAdj[BCD_W-2:0], shift_q[DATA_W-1]};
        shift_d     = {shift_q[DATA_W-2:0], 1'b0};
        ovfSticky_d = ovfSticky_q | bcdAdj[BCD_W-1];
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = UPDATE;
        end
        if (iLOAD) begin
          pendValid_d = 1'b1;
          pendValue_d = iVALUE;
        end
      end
      UPDATE: begin
        segStage_d = encSeg;
        ovfStage_d = ovfSticky_q;
        publish_d  = 1'b1;
        state_d    = IDLE;
        if (pendValid_q) begin
          loadEn    = 1'b1;
          loadValue = pendValue_q;
        end
        // A request arriving now always lands in the slot, even as the old one is consumed.
        pendValid_d = iLOAD;
        if (iLOAD) begin
          pendValue_d = iVALUE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (loadEn) begin
      shift_d     = loadValue;
      bcd_d       = '0;
      ovfSticky_d = 1'b0;
      cnt_d       = '0;
      state_d     = SHIFT;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      ovfSticky_q <= 1'b0;
      pendValid_q <= 1'b0;
      pendValue_q <= '0;
      segStage_q  <= BLANK_ALL;
      ovfStage_q  <= 1'b0;
      publish_q   <= 1'b0;
      seg_q       <= BLANK_ALL;
      ovfOut_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      ovfSticky_q <= ovfSticky_d;
      pendValid_q <= pendValid_d;
      pendValue_q <= pendValue_d;
      segStage_q  <= segStage_d;
      ovfStage_q  <= ovfStage_d;
      publish_q   <= publish_d;
      seg_q       <= seg_d;
      ovfOut_q    <= ovfOut_d;
      done_q      <= done_d;
    end
  end

  assign oBUSY = (state_q == SHIFT) || (state_q == UPDATE);
  assign oDONE = done_q;
  assign oOVF  = ovfOut_q;
  assign oSEG  = seg_q;

endmodule

// File: tb/tb_seg7_multi_digit_driver.sv
// Scoreboard bench for seg7_multi_digit_driver (DATA_W=32, DIGITS=6, active-low).
// Expected displays come from decimal arithmetic on the requested value.
module tb_seg7_multi_digit_driver;

  typedef struct {
    logic [47:0] seg;
    logic        ovf;
    int          doneCyc;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        iRST;
  logic [31:0] iVALUE;
  logic        iLOAD;
  logic        oBUSY;
  logic        oDONE;
  logic        oOVF;
  logic [47:0] oSEG;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbQ[$];

  seg7_multi_digit_driver #(
    .DATA_W     (32),
    .DIGITS     (6),
    .ACTIVE_LOW (1)
  ) dut (
    .iCLK   (clk),
    .iRST   (iRST),
    .iVALUE (iVALUE),
    .iLOAD  (iLOAD),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oOVF   (oOVF),
    .oSEG   (oSEG)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] glyphOf(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t makeExp(input logic [31:0] v, input int dc);
    exp_t            e;
    longint unsigned val;
    longint unsigned p;
    logic [7:0]      b;
    val       = {32'd0, v};
    e.val     = v;
    e.doneCyc = dc;
    e.ovf     = (val > 64'd999999);
    e.seg     = '0;
    p         = 1;
    for (int k = 0; k < 6; k++) begin
      if (e.ovf) begin
        b = 8'hBF;
      end else begin
        b = glyphOf(int'((val / p) % 10));
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && val < p) b = 8'hFF;
`endif
      end
      e.seg[8*k +: 8] = b;
      p = p * 10;
    end
    return e;
  endfunction

  function automatic logic [31:0] randValue();
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 9);
      1: return $urandom_range(0, 999);
      2: return $urandom_range(0, 999999);
      3: return $urandom_range(999990, 1000010);
      4: return $urandom;
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'd0;
          1: return 32'd999999;
          2: return 32'd1000000;
          default: return 32'hFFFFFFFF;
        endcase
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (oDONE === 1'b1) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got oDONE=1 with oSEG=%h at cycle %0d, required no pulse", oSEG, cyc);
        end else begin
          e = sbQ.pop_front();
          checkOutput($sformatf("seg(v=%0d)", e.val), 64'(oSEG), 64'(e.seg));
          checkOutput($sformatf("ovf(v=%0d)", e.val), 64'(oOVF), 64'(e.ovf));
          if (e.doneCyc >= 0) begin
            checkOutput($sformatf("done_cycle(v=%0d)", e.val), 64'(cyc), 64'(e.doneCyc));
          end
        end
      end
    end
  endtask

  // Called just after a falling edge; the next rising edge samples the request.
  task automatic pulseLoad(input logic [31:0] v);
    iVALUE = v;
    iLOAD  = 1'b1;
    @(negedge clk);
    iLOAD  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] first, input int nBusy, input logic [31:0] busyVals [3]);
    int          acc;
    logic [31:0] last;
    @(negedge clk);
    acc = cyc + 1;
    sbQ.push_back(makeExp(first, acc + 34));
    pulseLoad(first);
    checkOutput("busy_after_load", 64'(oBUSY), 64'd1);
    last = first;
    for (int i = 0; i < nBusy; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      last = busyVals[i];
      pulseLoad(last);
    end
    if (nBusy > 0) sbQ.push_back(makeExp(last, acc + 33 + 34));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", 64'(sbQ.size()), 64'd0);
    sbQ.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] bv [3];
    logic [31:0] directed [9];
    int          acc;
    directed = '{32'd1234, 32'd999999, 32'd1000000, 32'd0, 32'd1050,
                 32'hFFFFFFFF, 32'd9, 32'd100000, 32'd5};
    iRST   = 1'b1;
    iLOAD  = 1'b0;
    iVALUE = '0;
    fork
      monitorLoop();
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset_seg", 64'(oSEG), 64'hFFFF_FFFF_FFFF);
    checkOutput("reset_busy", 64'(oBUSY), 64'd0);
    checkOutput("reset_done", 64'(oDONE), 64'd0);
    checkOutput("reset_ovf", 64'(oOVF), 64'd0);
    iRST = 1'b0;

    bv = '{32'd0, 32'd0, 32'd0};
    foreach (directed[i]) begin
      applyStimulus(directed[i], 0, bv);
      waitDrain();
    end

    bv = '{32'd5, 32'd42, 32'd0};
    applyStimulus(32'd77, 2, bv);
    waitDrain();

    repeat (25) begin
      bv = '{randValue(), randValue(), randValue()};
      applyStimulus(randValue(), $urandom_range(0, 3), bv);
      waitDrain();
    end

    // Request landing exactly in the UPDATE cycle must still be displayed.
    @(negedge clk);
    acc = cyc + 1;
    sbQ.push_back(makeExp(32'd321, acc + 34));
    pulseLoad(32'd321);
    while (cyc < acc + 32) @(negedge clk);
    sbQ.push_back(makeExp(32'd654, -1));
    pulseLoad(32'd654);
    waitDrain();

    // Reset during SHIFT with a request pending: nothing may be published afterwards.
    @(negedge clk);
    pulseLoad(32'd111);
    pulseLoad(32'd222);
    repeat (7) @(negedge clk);
    iRST = 1'b1;
    @(negedge clk);
    iRST = 1'b0;
    checkOutput("abort_busy", 64'(oBUSY), 64'd0);
    checkOutput("abort_seg", 64'(oSEG), 64'hFFFF_FFFF_FFFF);
    checkOutput("abort_ovf", 64'(oOVF), 64'd0);
    checkOutput("abort_done", 64'(oDONE), 64'd0);
    repeat (80) @(negedge clk);
    checkOutput("abort_seg_held", 64'(oSEG), 64'hFFFF_FFFF_FFFF);
    checkOutput("abort_idle", 64'(oBUSY), 64'd0);

    // Load coinciding with reset is discarded.
    iRST   = 1'b1;
    iLOAD  = 1'b1;
    iVALUE = 32'd5;
    @(negedge clk);
    iRST  = 1'b0;
    iLOAD = 1'b0;
    checkOutput("reset_beats_load_busy", 64'(oBUSY), 64'd0);
    repeat (50) @(negedge clk);
    checkOutput("reset_beats_load_seg", 64'(oSEG), 64'hFFFF_FFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
